// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the memory game round
//                controller: FSM state encoding, LFSR geometry, round count,
//                timer type and two small helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Number of rounds in one game; score saturates at this value.
    localparam int NUM_ROUNDS = 4;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (1-based) -> bit mask 15,13,12,10
    localparam int              c_lfsr_width = 16;
    localparam logic [15:0]     c_lfsr_taps  = 16'hB400;

    // Shared down-timer
    localparam int c_timer_width = 28;
    typedef logic [c_timer_width-1:0] timer_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHOW  = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    function automatic logic [c_lfsr_width-1:0] lfsr_next(input logic [c_lfsr_width-1:0] v);
        return {v[c_lfsr_width-2:0], ^(v & c_lfsr_taps)};
    endfunction

    // An all-zero nibble would be an unwinnable round, so force it to 4'b0001.
    function automatic logic [15:0] fix_pattern(input logic [15:0] v);
        logic [15:0] f;
        f = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] == 4'b0000) begin
                f[i*4 +: 4] = 4'b0001;
            end
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchronizer for raw push buttons followed by a
//                rising-edge detector (one-cycle press pulse per bit).
//  Ports       : osc_clk  - clock
//                reset_n  - asynchronous active-low reset
//                button   - raw asynchronous buttons, active-high
//                press    - one-cycle pulse on each synchronized 0->1 edge
//  Revision    : 1.0  initial release
// ============================================================================
module btn_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             osc_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_sync_d;

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_meta   <= button;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign press = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_ctrl
//  Description : Four-round memory game. Each round shows a 4-bit LED pattern
//                for SHOW_TICKS cycles, then gives the player RESP_TICKS
//                cycles to press exactly the shown buttons. Score and LEDs
//                are registered.
//  Ports       : osc_clk  - clock          reset_n - async active-low reset
//                start    - begin a game (IDLE/OVER only)
//                button   - raw push buttons, bit i pairs with led[i]
//                led      - LED drive      score   - rounds won (0..4)
//                busy     - game in progress
//                done     - game over, result on led
//  Revision    : 1.0  initial release
// ============================================================================
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int          SHOW_TICKS = 50_000_000,
    parameter int          RESP_TICKS = 150_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       osc_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] button,
    output logic [3:0] led,
    output logic [2:0] score,
    output logic       busy,
    output logic       done
);

    localparam timer_t c_show_load = timer_t'(SHOW_TICKS - 1);
    localparam timer_t c_resp_load = timer_t'(RESP_TICKS - 1);

    state_t      r_state,   w_state;
    logic [15:0] r_lfsr;
    logic [15:0] r_pattern, w_pattern;
    logic [1:0]  r_round,   w_round;
    timer_t      r_timer,   w_timer;
    logic [3:0]  r_resp,    w_resp;
    logic        r_hit,     w_hit;
    logic [3:0]  r_led,     w_led;
    logic [2:0]  r_score,   w_score;
    logic        r_busy,    w_busy;
    logic        r_done,    w_done;

    logic [3:0]  w_press;
    logic [15:0] w_new_pattern;
    logic [3:0]  w_target;
    logic [1:0]  w_round_inc;
    logic [3:0]  w_acc;
    logic [2:0]  w_score_upd;

    btn_sync_edge #(.WIDTH(4)) u_btn (
        .osc_clk (osc_clk),
        .reset_n (reset_n),
        .button  (button),
        .press   (w_press)
    );

    assign w_new_pattern = fix_pattern(r_lfsr);
    assign w_target      = r_pattern[{r_round, 2'b00} +: 4];
    assign w_round_inc   = r_round + 2'd1;
    // Presses only accumulate while waiting; outside WAIT r_resp is unused.
    assign w_acc         = r_resp | w_press;
    // Guard keeps score from ever wrapping even if a round were miscounted.
    assign w_score_upd   = (r_hit && (r_score != 3'(NUM_ROUNDS))) ? (r_score + 3'd1) : r_score;

    always_comb begin
        w_state   = r_state;
        w_pattern = r_pattern;
        w_round   = r_round;
        w_timer   = r_timer;
        w_resp    = r_resp;
        w_hit     = r_hit;
        w_led     = r_led;
        w_score   = r_score;

        case (r_state)
            S_IDLE: begin
                w_led = 4'b0000;
                if (start) begin
                    w_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pattern = w_new_pattern;
                w_round   = 2'd0;
                w_score   = 3'd0;
                w_timer   = c_show_load;
                w_led     = w_new_pattern[3:0];
                w_state   = S_SHOW;
            end
            S_SHOW: begin
                if (r_timer == '0) begin
                    w_state = S_WAIT;
                    w_led   = 4'b0000;
                    w_resp  = 4'b0000;
                    w_timer = c_resp_load;
                end else begin
                    w_timer = r_timer - timer_t'(1);
                end
            end
            S_WAIT: begin
                // Hit is tested first so a completing press on the last tick
                // wins over the timeout; any stray bit breaks equality, so a
                // stray bit arriving with the completing bit is a miss.
                if (w_acc == w_target) begin
                    w_hit   = 1'b1;
                    w_state = S_CHECK;
                end else if ((|(w_acc & ~w_target)) || (r_timer == '0)) begin
                    w_hit   = 1'b0;
                    w_state = S_CHECK;
                end else begin
                    w_resp  = w_acc;
                    w_timer = r_timer - timer_t'(1);
                end
            end
            S_CHECK: begin
                w_score = w_score_upd;
                if (r_round == 2'(NUM_ROUNDS - 1)) begin
                    w_state = S_OVER;
                    w_led   = (w_score_upd == 3'(NUM_ROUNDS)) ? 4'b1111 : {1'b0, w_score_upd};
                end else begin
                    w_round = w_round_inc;
                    w_timer = c_show_load;
                    w_led   = r_pattern[{w_round_inc, 2'b00} +: 4];
                    w_state = S_SHOW;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state = S_LOAD;
                    w_led   = 4'b0000;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_led   = 4'b0000;
            end
        endcase

        w_busy = (w_state != S_IDLE) && (w_state != S_OVER);
        w_done = (w_state == S_OVER);
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_pattern <= '0;
            r_round   <= '0;
            r_timer   <= '0;
            r_resp    <= '0;
            r_hit     <= 1'b0;
            r_led     <= '0;
            r_score   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            // Free-running: pattern randomness comes from when start arrives.
            r_lfsr    <= lfsr_next(r_lfsr);
            r_pattern <= w_pattern;
            r_round   <= w_round;
            r_timer   <= w_timer;
            r_resp    <= w_resp;
            r_hit     <= w_hit;
            r_led     <= w_led;
            r_score   <= w_score;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign led   = r_led;
    assign score = r_score;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_round_ctrl
//  Description : Self-checking bench for game_round_ctrl (SHOW_TICKS=4,
//                RESP_TICKS=10). Table of whole-game scenarios plus
//                hand-written corner sequences; expectations flow through a
//                scoreboard queue and are compared on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_round_ctrl;

    localparam int c_show = 4;
    localparam int c_resp = 10;

    typedef enum int {A_NONE, A_HIT, A_MISS, A_LATE} act_t;

    typedef struct {
        string      name;
        logic [3:0] led;
        logic [2:0] score;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        string name;
        act_t  acts [4];
        int    exp_score;
    } game_vec_t;

    logic       osc_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start   = 1'b0;
    logic [3:0] button  = 4'h0;
    logic [3:0] led;
    logic [2:0] score;
    logic       busy;
    logic       done;

    exp_t        sb_q [$];
    game_vec_t   tbl  [5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          g_score  = 0;
    logic [15:0] m_lfsr;
    logic [15:0] pat;

    game_round_ctrl #(
        .SHOW_TICKS (c_show),
        .RESP_TICKS (c_resp),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .osc_clk (osc_clk),
        .reset_n (reset_n),
        .start   (start),
        .button  (button),
        .led     (led),
        .score   (score),
        .busy    (busy),
        .done    (done)
    );

    always #5 osc_clk = ~osc_clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] fix_pat(input logic [15:0] v);
        logic [15:0] f;
        f = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] == 4'h0) f[i*4 +: 4] = 4'h1;
        end
        return f;
    endfunction

    function automatic logic [3:0] over_led(input int s);
        return (s == 4) ? 4'hF : {1'b0, 3'(s)};
    endfunction

    // Reference LFSR: same seed, advances every cycle, reloads on reset.
    always @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= step(m_lfsr);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [3:0] l, input int s,
                            input logic b, input logic d);
        exp_t e;
        e.name  = nm;
        e.led   = l;
        e.score = 3'(s);
        e.busy  = b;
        e.done  = d;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        if (led !== e.led || score !== e.score || busy !== e.busy || done !== e.done) begin
            n_fail++;
            $display("FAIL %s: got led=%b score=%0d busy=%b done=%b, expected led=%b score=%0d busy=%b done=%b",
                     e.name, led, score, busy, done, e.led, e.score, e.busy, e.done);
        end
    endtask

    task automatic expect_now(input string nm, input logic [3:0] l, input int s,
                              input logic b, input logic d);
        push_exp(nm, l, s, b, d);
        @(negedge osc_clk);
        pop_cmp();
    endtask

    task automatic expect_async(input string nm, input logic [3:0] l, input int s,
                                input logic b, input logic d);
        push_exp(nm, l, s, b, d);
        pop_cmp();
    endtask

    // Called just after the clock edge; returns just after SHOW of round 0 begins.
    task automatic start_game_now();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        pat = fix_pat(m_lfsr);
        g_score = 0;
        tick(1);
    endtask

    task automatic start_game();
        @(posedge osc_clk);
        #1;
        start_game_now();
    endtask

    // Entered just after the edge that starts SHOW of round r; returns just
    // after the edge that leaves CHECK (next SHOW or OVER).
    task automatic play_round(input int r, input act_t act);
        logic [3:0] tgt;
        logic [3:0] wrong;
        logic [3:0] low;
        tgt   = pat[r*4 +: 4];
        wrong = ~tgt;
        low   = tgt & (~tgt + 4'd1);
        expect_now($sformatf("show_r%0d", r), tgt, g_score, 1'b1, 1'b0);
        tick(c_show);
        expect_now($sformatf("wait_r%0d", r), 4'h0, g_score, 1'b1, 1'b0);
        case (act)
            A_HIT: begin
                button = tgt;
                tick(4);
                g_score++;
            end
            A_MISS: begin
                if (wrong != 4'h0) begin
                    button = wrong;
                    tick(4);
                end else begin
                    tick(c_resp + 1);
                end
            end
            A_LATE: begin
                // Completing bit lands on the cycle the timer reaches zero.
                button = tgt & ~low;
                tick(7);
                button = tgt;
                tick(4);
                g_score++;
            end
            default: tick(c_resp + 1);
        endcase
        button = 4'h0;
    endtask

    task automatic set_vec(input int i, input string nm, input act_t a0, input act_t a1,
                           input act_t a2, input act_t a3, input int sc);
        tbl[i].name      = nm;
        tbl[i].acts[0]   = a0;
        tbl[i].acts[1]   = a1;
        tbl[i].acts[2]   = a2;
        tbl[i].acts[3]   = a3;
        tbl[i].exp_score = sc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] nxt;
        logic [3:0]  t0;
        bit          found;

        set_vec(0, "all_hit",  A_HIT,  A_HIT,  A_HIT,  A_HIT,  4);
        set_vec(1, "all_none", A_NONE, A_NONE, A_NONE, A_NONE, 0);
        set_vec(2, "mixed",    A_HIT,  A_MISS, A_LATE, A_NONE, 2);
        set_vec(3, "late_all", A_LATE, A_LATE, A_LATE, A_LATE, 4);
        set_vec(4, "miss_all", A_MISS, A_MISS, A_MISS, A_MISS, 0);

        // Power-on reset
        #2 reset_n = 1'b0;
        #1 expect_async("reset_outputs", 4'h0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge osc_clk);
        #2 reset_n = 1'b1;
        tick(2);
        expect_now("idle_after_reset", 4'h0, 0, 1'b0, 1'b0);

        // Whole-game scenarios
        for (int i = 0; i < 5; i++) begin
            start_game();
            for (int r = 0; r < 4; r++) begin
                play_round(r, tbl[i].acts[r]);
            end
            expect_now({tbl[i].name, "_over"}, over_led(tbl[i].exp_score),
                       tbl[i].exp_score, 1'b0, 1'b1);
        end

        // start ignored while busy; held button not counted until re-pressed
        start_game();
        t0 = pat[3:0];
        button = t0;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(c_show - 1);
        expect_now("held_wait_entry", 4'h0, 0, 1'b1, 1'b0);
        start = 1'b1;
        tick(1);
        start  = 1'b0;
        button = 4'h0;
        tick(1);
        button = t0;
        tick(3);
        expect_now("held_check_cycle", 4'h0, 0, 1'b1, 1'b0);
        tick(1);
        expect_now("held_repress_hit", pat[7:4], 1, 1'b1, 1'b0);
        button = 4'h0;

        // Reset mid-SHOW abandons the game immediately
        #1 reset_n = 1'b0;
        #1 expect_async("reset_mid_show", 4'h0, 0, 1'b0, 1'b0);
        @(posedge osc_clk);
        #2 reset_n = 1'b1;
        tick(c_show + 2);
        expect_now("idle_hold_after_reset", 4'h0, 0, 1'b0, 1'b0);

        // Target 4'b0101 in round 0: bit0 then stray bit1 -> miss
        found = 1'b0;
        @(posedge osc_clk);
        #1;
        for (int i = 0; i < 4000 && !found; i++) begin
            nxt = fix_pat(step(m_lfsr));
            if (nxt[3:0] == 4'b0101) found = 1'b1;
            else tick(1);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL target_search: no 0101 pattern within 4000 cycles");
        end else begin
            start_game_now();
            expect_now("miss_show_r0", 4'b0101, 0, 1'b1, 1'b0);
            tick(c_show);
            expect_now("miss_wait_r0", 4'h0, 0, 1'b1, 1'b0);
            button = 4'b0001;
            tick(2);
            button = 4'b0011;
            tick(3);
            expect_now("miss_check", 4'h0, 0, 1'b1, 1'b0);
            tick(1);
            button = 4'h0;
            for (int r = 1; r < 4; r++) begin
                play_round(r, A_NONE);
            end
            expect_now("miss_game_over", 4'h0, 0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter SHOW_TICKS, default 50_000_000, osc_clk cycles a round pattern is displayed (1 s at 50 MHz).
REQ-002 Parameter RESP_TICKS, default 150_000_000, osc_clk cycles allowed for the player response.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 osc_clk  input  1  sole clock; all state rising-edge triggered.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  synchronous level; sampled high in IDLE or OVER begins a game.
REQ-007 button  input  4  asynchronous raw push buttons, active-high, bit i pairs with led[i].
REQ-008 led  output  4  registered LED drive.
REQ-009 score  output  3  registered count of rounds won, 0..4.
REQ-010 busy  output  1  high in every state except IDLE and OVER.
REQ-011 done  output  1  high while in OVER.

Function
REQ-012 button SHALL pass through a 2-flop synchronizer; press = synchronized bit 0->1 transition (one-cycle pulse per bit).
REQ-013 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle regardless of state; pattern randomness comes from start timing.
REQ-014 States: IDLE, LOAD, SHOW, WAIT, CHECK, OVER; one state register, one shared 28-bit down-timer.
REQ-015 IDLE: led=0; start=1 -> LOAD next cycle.
REQ-016 LOAD (1 cycle): pattern <= LFSR value with any all-zero nibble replaced by 4'b0001; round <= 0; score <= 0; timer <= SHOW_TICKS-1; -> SHOW.
REQ-017 SHOW: led = pattern[round*4 +: 4]; timer decrements; at timer==0 -> WAIT, led <= 0, resp <= 0, timer <= RESP_TICKS-1.
REQ-018 WAIT: resp <= resp | press; hit when (resp|press)==target; miss when (resp|press) has any bit outside target, or timer==0 without hit.
REQ-019 Hit and timeout in the same cycle SHALL count as hit; miss bit and completing bit in same cycle SHALL count as miss.
REQ-020 Presses outside WAIT SHALL be ignored; a button already held on WAIT entry counts only after release and re-press.
REQ-021 CHECK (1 cycle): score += hit; if round==3 -> OVER, else round += 1, timer <= SHOW_TICKS-1, -> SHOW.
REQ-022 OVER: led = 4'b1111 when score==4, else {1'b0, score}; start=1 -> LOAD (new game, new pattern).
REQ-023 start while busy SHALL be ignored; score SHALL saturate structurally at 4 (never wraps).
REQ-024 Every change of led, score, busy, done SHALL occur one cycle after the causing input/timer event (registered outputs).

Reset
REQ-025 reset_n low SHALL asynchronously force: state=IDLE, led=0, score=0, round=0, timer=0, resp=0, pattern=0, sync flops=0, LFSR=LFSR_SEED.
REQ-026 Reset asserted mid-game SHALL abandon the game; after release the block sits in IDLE until start.

Structure
REQ-027 Shared package game_pkg SHALL hold the state enum, LFSR width/taps, and the NUM_ROUNDS=4 constant.
REQ-028 Synchronizer + edge detector SHALL be one sub-module, btn_sync_edge (4 bits wide, same osc_clk/reset_n).
REQ-029 No $urandom or other non-synthesizable randomness inside the RTL.

Verification (SHOW_TICKS=4, RESP_TICKS=10)
REQ-030 Reset mid-SHOW -> led=0, score=0, busy=0, done=0 immediately; LFSR reloads 16'hACE1.
REQ-031 start, then per round press exactly the shown bits in WAIT -> score=4 after round 4, done=1, led=4'b1111.
REQ-032 Target 4'b0101; press bit0, then bit1 -> miss on bit1 press, score unchanged, next round SHOW one cycle after CHECK.
REQ-033 No presses in any round -> each WAIT lasts 10 cycles; OVER with score=0, led=4'b0000.
REQ-034 Final required press in the same cycle as timer==0 -> counted as hit (score increments).
REQ-035 start pulsed during SHOW/WAIT -> no effect; button held across SHOW->WAIT boundary -> not counted until re-pressed.
